updown_counter_mod: RTL and testbench

//  Parametrised up/down counter: programmable modulus, step size, synchronous load,
//  and run-time wrap/saturate mode. Successor to the fixed 3-bit wrap counter.

---
 rtl/updown_counter_mod.sv | 142 ++++++++++++++
 tb/tb_updown_counter_mod.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_mod.sv
// -----------------------------------------------------------------------------
// updown_counter_mod
// Parametrised up/down counter with programmable modulus (MAX_VAL+1), run-time
// step size, synchronous load and a run-time wrap/saturate mode. The count and
// the wrapped/saturated pulses are registered; at_max/at_min decode the
// registered count combinationally.
//
// Parameters
//   WIDTH       count width in bits (>= 2)
//   MAX_VAL     upper count limit, 1 .. 2**WIDTH-1; count spans 0..MAX_VAL
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   enable_i     apply one step this cycle
//   dir_i        1 = count up, 0 = count down
//   mode_i       0 = wrap modulo MAX_VAL+1, 1 = saturate at 0 / MAX_VAL
//   step_i       step magnitude (clamped to MAX_VAL)
//   load_i       synchronous load strobe, highest priority
//   load_val_i   load value (clamped to MAX_VAL)
//   count_o      registered count
//   wrapped_o    registered pulse: last update crossed a limit in wrap mode
//   saturated_o  registered pulse: last update was clamped in saturate mode
//   at_max_o     count_o == MAX_VAL
//   at_min_o     count_o == 0
// -----------------------------------------------------------------------------
module updown_counter_mod #(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = (1 << WIDTH) - 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic             dir_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] step_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             wrapped_o,
    output logic             saturated_o,
    output logic             at_max_o,
    output logic             at_min_o
);

    // Limits held one bit wider so that count+step and the modulus never overflow.
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   MOD_EXT = MAX_EXT + {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrapped_q, wrapped_d;
    logic             saturated_q, saturated_d;

    logic [WIDTH:0] cnt_ext_s;
    logic [WIDTH:0] step_ext_s;
    logic [WIDTH:0] eff_s;
    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] up_wrap_s;
    logic [WIDTH:0] dn_diff_s;
    logic [WIDTH:0] dn_wrap_s;

    // Step arithmetic in WIDTH+1 bits; eff_s is the step clamped to MAX_VAL.
    always_comb begin
        cnt_ext_s  = {1'b0, count_q};
        step_ext_s = {1'b0, step_i};
        if (step_ext_s > MAX_EXT) begin
            eff_s = MAX_EXT;
        end else begin
            eff_s = step_ext_s;
        end
        sum_s     = cnt_ext_s + eff_s;
        up_wrap_s = sum_s - MOD_EXT;
        dn_diff_s = cnt_ext_s - eff_s;
        dn_wrap_s = cnt_ext_s + MOD_EXT - eff_s;
    end

    // Next-state selection: load beats enable beats hold; flags default low.
    always_comb begin
        count_d     = count_q;
        wrapped_d   = 1'b0;
        saturated_d = 1'b0;
        if (load_i) begin
            if (load_val_i > MAX_W) begin
                count_d = MAX_W;
            end else begin
                count_d = load_val_i;
            end
        end else if (enable_i) begin
            if (eff_s == {(WIDTH+1){1'b0}}) begin
                count_d = count_q;
            end else if (dir_i) begin
                // A count already above MAX_VAL also lands here as over the limit.
                if (sum_s > MAX_EXT) begin
                    if (mode_i) begin
                        count_d     = MAX_W;
                        saturated_d = 1'b1;
                    end else begin
                        count_d   = up_wrap_s[WIDTH-1:0];
                        wrapped_d = 1'b1;
                    end
                end else begin
                    count_d = sum_s[WIDTH-1:0];
                end
            end else begin
                if (eff_s > cnt_ext_s) begin
                    if (mode_i) begin
                        count_d     = {WIDTH{1'b0}};
                        saturated_d = 1'b1;
                    end else begin
                        count_d   = dn_wrap_s[WIDTH-1:0];
                        wrapped_d = 1'b1;
                    end
                end else begin
                    count_d = dn_diff_s[WIDTH-1:0];
                end
            end
        end else begin
            count_d = count_q;
        end
    end

    // State register: count and the one-cycle flag pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q     <= {WIDTH{1'b0}};
            wrapped_q   <= 1'b0;
            saturated_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            wrapped_q   <= wrapped_d;
            saturated_q <= saturated_d;
        end
    end

    assign count_o     = count_q;
    assign wrapped_o   = wrapped_q;
    assign saturated_o = saturated_q;
    assign at_max_o    = (count_q == MAX_W);
    assign at_min_o    = (count_q == {WIDTH{1'b0}});

endmodule

// File: tb/tb_updown_counter_mod.sv
// -----------------------------------------------------------------------------
// tb_updown_counter_mod
// Two instances: A (WIDTH=3, MAX_VAL=7) and B (WIDTH=8, MAX_VAL=9).
// Stimulus pushes hand-computed expected results into a per-instance queue;
// monitors pop and compare one entry per clock after the edge.
// -----------------------------------------------------------------------------
module tb_updown_counter_mod;

    typedef struct {
        logic [7:0] cnt;
        logic       wr;
        logic       sat;
        logic       amax;
        logic       amin;
    } exp_t;

    logic clk;
    int   n_checks;
    int   n_fail;
    exp_t qa[$];
    exp_t qb[$];

    // Instance A signals
    logic       a_rst_n, a_en, a_dir, a_mode, a_load;
    logic [2:0] a_step, a_lv, a_cnt;
    logic       a_wr, a_sat, a_amax, a_amin;

    // Instance B signals
    logic       b_rst_n, b_en, b_dir, b_mode, b_load;
    logic [7:0] b_step, b_lv, b_cnt;
    logic       b_wr, b_sat, b_amax, b_amin;

    updown_counter_mod #(.WIDTH(3), .MAX_VAL(7)) dut_a (
        .clk_i(clk), .rst_ni(a_rst_n), .enable_i(a_en), .dir_i(a_dir),
        .mode_i(a_mode), .step_i(a_step), .load_i(a_load), .load_val_i(a_lv),
        .count_o(a_cnt), .wrapped_o(a_wr), .saturated_o(a_sat),
        .at_max_o(a_amax), .at_min_o(a_amin)
    );

    updown_counter_mod #(.WIDTH(8), .MAX_VAL(9)) dut_b (
        .clk_i(clk), .rst_ni(b_rst_n), .enable_i(b_en), .dir_i(b_dir),
        .mode_i(b_mode), .step_i(b_step), .load_i(b_load), .load_val_i(b_lv),
        .count_o(b_cnt), .wrapped_o(b_wr), .saturated_o(b_sat),
        .at_max_o(b_amax), .at_min_o(b_amin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks = n_checks + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_a(input logic [2:0] st, input logic [7:0] ec, input logic ew);
        exp_t e;
        a_en = 1'b1; a_dir = 1'b1; a_mode = 1'b0; a_step = st; a_load = 1'b0;
        e.cnt = ec; e.wr = ew; e.sat = 1'b0;
        e.amax = (ec == 8'd7); e.amin = (ec == 8'd0);
        qa.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_b(input logic ld, input logic [7:0] lv, input logic en,
                           input logic d, input logic m, input logic [7:0] st,
                           input logic [7:0] ec, input logic ew, input logic es);
        exp_t e;
        b_load = ld; b_lv = lv; b_en = en; b_dir = d; b_mode = m; b_step = st;
        e.cnt = ec; e.wr = ew; e.sat = es;
        e.amax = (ec == 8'd9); e.amin = (ec == 8'd0);
        qb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor for instance A
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("a_count", int'(a_cnt), int'(e.cnt));
                chk("a_wrapped", int'(a_wr), int'(e.wr));
                chk("a_saturated", int'(a_sat), int'(e.sat));
                chk("a_at_max", int'(a_amax), int'(e.amax));
                chk("a_at_min", int'(a_amin), int'(e.amin));
            end
        end
    end

    // Monitor for instance B
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("b_count", int'(b_cnt), int'(e.cnt));
                chk("b_wrapped", int'(b_wr), int'(e.wr));
                chk("b_saturated", int'(b_sat), int'(e.sat));
                chk("b_at_max", int'(b_amax), int'(e.amax));
                chk("b_at_min", int'(b_amin), int'(e.amin));
            end
        end
    end

    // Directed stimulus
    initial begin
        logic [7:0] seq_a [9];
        n_checks = 0;
        n_fail   = 0;
        a_rst_n = 1'b0; a_en = 1'b0; a_dir = 1'b1; a_mode = 1'b0;
        a_step = 3'd0; a_load = 1'b0; a_lv = 3'd0;
        b_rst_n = 1'b0; b_en = 1'b0; b_dir = 1'b1; b_mode = 1'b0;
        b_step = 8'd0; b_load = 1'b0; b_lv = 8'd0;

        // Reset state, observed without any clock edge
        #3;
        chk("rst_a_count", int'(a_cnt), 0);
        chk("rst_a_at_min", int'(a_amin), 1);
        chk("rst_a_at_max", int'(a_amax), 0);
        chk("rst_b_count", int'(b_cnt), 0);
        chk("rst_b_flags", int'({b_wr, b_sat}), 0);
        chk("rst_b_at_min", int'(b_amin), 1);
        chk("rst_b_at_max", int'(b_amax), 0);
        @(negedge clk);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;

        // 1: 3-bit wrap counter, step 1 up: 1..7, 0 (wrapped), 1
        seq_a = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd0, 8'd1};
        for (int i = 0; i < 9; i++) begin
            drive_a(3'd1, seq_a[i], (seq_a[i] == 8'd0));
        end
        a_en = 1'b0;

        // 2: MAX=9 wrap, step 3 down from 1: 1, 8 (wrapped), 5
        drive_b(1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 8'd3, 8'd1, 1'b0, 1'b0);
        drive_b(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd3, 8'd8, 1'b1, 1'b0);
        drive_b(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd3, 8'd5, 1'b0, 1'b0);
        // hold: flags drop
        drive_b(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd3, 8'd5, 1'b0, 1'b0);

        // 3: saturate up, step 4 from 7: 9,9,9 with saturated each cycle
        drive_b(1'b1, 8'd7, 1'b0, 1'b1, 1'b1, 8'd4, 8'd7, 1'b0, 1'b0);
        drive_b(1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'd4, 8'd9, 1'b0, 1'b1);
        drive_b(1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'd4, 8'd9, 1'b0, 1'b1);
        drive_b(1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'd4, 8'd9, 1'b0, 1'b1);

        // 4: load 200 clamps to 9; simultaneous enable (would wrap) is ignored
        drive_b(1'b1, 8'd200, 1'b1, 1'b1, 1'b0, 8'd1, 8'd9, 1'b0, 1'b0);

        // 5: step 0 holds with no flags; step 255 clamps to 9 from 0, no wrap
        drive_b(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd9, 1'b0, 1'b0);
        drive_b(1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        drive_b(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd255, 8'd9, 1'b0, 1'b0);

        // Saturate down, step 4 from 9: 5, 1, 0 (sat), 0 (sat, already at limit)
        drive_b(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 8'd4, 8'd5, 1'b0, 1'b0);
        drive_b(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 8'd4, 8'd1, 1'b0, 1'b0);
        drive_b(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 8'd4, 8'd0, 1'b0, 1'b1);
        drive_b(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 8'd4, 8'd0, 1'b0, 1'b1);

        // Wrap up: 9 + 6 -> 5 with wrapped high, then reset mid-cycle
        drive_b(1'b1, 8'd9, 1'b0, 1'b1, 1'b0, 8'd6, 8'd9, 1'b0, 1'b0);
        drive_b(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd6, 8'd5, 1'b1, 1'b0);

        // 6: pending load of 3, reset between edges clears everything at once
        b_en = 1'b0; b_load = 1'b1; b_lv = 8'd3;
        #2 b_rst_n = 1'b0;
        #1;
        chk("mid_rst_count", int'(b_cnt), 0);
        chk("mid_rst_wrapped", int'(b_wr), 0);
        chk("mid_rst_saturated", int'(b_sat), 0);
        chk("mid_rst_at_min", int'(b_amin), 1);
        #1 b_rst_n = 1'b1;
        b_load = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_hold", int'(b_cnt), 0);
        drive_b(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd1, 8'd1, 1'b0, 1'b0);
        drive_b(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd1, 8'd2, 1'b0, 1'b0);
        b_en = 1'b0;

        // Every pushed expectation must have been consumed by a monitor
        repeat (2) @(negedge clk);
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
